// File: rtl/audio_sample_sequencer_if.sv
// Codec-side read/write handshake bundle for audio_sample_sequencer.
// The sequencer is the master: it issues the read/write strobes and drives the DAC samples.
interface audio_sample_sequencer_if #(
    parameter int DATA_W = 24
);
    logic              read_ready;
    logic              write_ready;
    logic [DATA_W-1:0] readdata_left;
    logic [DATA_W-1:0] readdata_right;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;

    modport master (
        input  read_ready, write_ready, readdata_left, readdata_right,
        output read, write, writedata_left, writedata_right
    );

    modport slave (
        output read_ready, write_ready, readdata_left, readdata_right,
        input  read, write, writedata_left, writedata_right
    );
endinterface

// File: rtl/audio_sample_sequencer.sv
// Moves one stereo frame per transaction from the codec ADC (or the tone ROM, or silence)
// to the codec DAC, and owns the tone-ROM address counter.
module audio_sample_sequencer #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 16,
    parameter int TONE_LEN = 48000,
    parameter int ROM_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      src_sel,
    input  logic                      mute,
    input  logic [DATA_W-1:0]         rom_q,
    audio_sample_sequencer_if.master  codec,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      frame_done,
    output logic [15:0]               stall_cnt
);

    typedef enum logic [1:0] {IDLE, CAPTURE, FETCH, WRITE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TONE_LEN - 1);
    localparam logic [1:0]        LAST_LAT  = 2'(ROM_LAT - 1);

    state_t            state;
    state_t            next_state;
    logic              rd_strobe;
    logic              wr_strobe;
    logic              load;
    logic [1:0]        lat_cnt;
    logic              src_lat;
    logic              mute_lat;
    logic [DATA_W-1:0] left_lat;
    logic [DATA_W-1:0] right_lat;
    logic [DATA_W-1:0] wd_left;
    logic [DATA_W-1:0] wd_right;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_strobe  = 1'b0;
        wr_strobe  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (codec.read_ready && codec.write_ready) next_state = CAPTURE;
            end
            CAPTURE: begin
                rd_strobe  = codec.read_ready;
                next_state = codec.read_ready ? FETCH : IDLE;
            end
            FETCH: begin
                if (lat_cnt == LAST_LAT) begin
                    load       = 1'b1;
                    next_state = WRITE;
                end
            end
            WRITE: begin
                wr_strobe = codec.write_ready;
                if (codec.write_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // rom_addr only moves on the write edge, so it is stable for the whole next frame
    // and rom_q has settled by the time FETCH ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt   <= '0;
            src_lat   <= 1'b0;
            mute_lat  <= 1'b0;
            left_lat  <= '0;
            right_lat <= '0;
            wd_left   <= '0;
            wd_right  <= '0;
            rom_addr  <= '0;
            stall_cnt <= '0;
        end else begin
            if (rd_strobe) begin
                src_lat   <= src_sel;
                mute_lat  <= mute;
                left_lat  <= codec.readdata_left;
                right_lat <= codec.readdata_right;
            end
            if (state == FETCH) lat_cnt <= lat_cnt + 2'd1;
            else                lat_cnt <= '0;
            if (load) begin
                if (mute_lat) begin
                    wd_left  <= '0;
                    wd_right <= '0;
                end else if (src_lat) begin
                    wd_left  <= rom_q;
                    wd_right <= rom_q;
                end else begin
                    wd_left  <= left_lat;
                    wd_right <= right_lat;
                end
            end
            if (wr_strobe && src_lat)
                rom_addr <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + ADDR_W'(1);
            if (state == WRITE && !codec.write_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign codec.read            = rd_strobe;
    assign codec.write           = wr_strobe;
    assign codec.writedata_left  = wd_left;
    assign codec.writedata_right = wd_right;
    assign frame_done            = wr_strobe;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Self-checking bench for audio_sample_sequencer: directed frame table, randomized traffic
// against a frame-level scoreboard, and an asynchronous reset in the middle of a frame.
module tb_audio_sample_sequencer;

    localparam int DATA_W   = 24;
    localparam int ADDR_W   = 16;
    localparam int TONE_LEN = 4;
    localparam int ROM_LAT  = 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              src_sel = 1'b0;
    logic              mute = 1'b0;
    logic [DATA_W-1:0] rom_q = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic              frame_done;
    logic [15:0]       stall_cnt;

    audio_sample_sequencer_if #(.DATA_W(DATA_W)) codec_if ();

    audio_sample_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TONE_LEN(TONE_LEN), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .src_sel(src_sel), .mute(mute), .rom_q(rom_q),
        .codec(codec_if), .rom_addr(rom_addr), .frame_done(frame_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Tone contents: distinct, nonzero word per address.
    function automatic logic [DATA_W-1:0] rom_model(input logic [ADDR_W-1:0] a);
        return {8'hC0 ^ a[7:0], ~a[7:0], a[7:0] ^ 8'h5A};
    endfunction

    always @(posedge clk) rom_q <= rom_model(rom_addr);

    typedef struct {
        logic              src;
        logic              mute;
        logic              flip;
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
        int                stall;
        logic [DATA_W-1:0] exp_left;
        logic [DATA_W-1:0] exp_right;
        logic [ADDR_W-1:0] exp_addr;
        logic [15:0]       exp_stall;
    } vec_t;

    typedef struct {
        logic              got;
        int                lat;
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       stall;
    } res_t;

    vec_t vecs[13];
    vec_t post_reset_vec;
    res_t res;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard state: one outstanding frame at most.
    int                cyc = 0;
    int                rst_req = 0;
    int                rst_seen = 0;
    logic              pending = 1'b0;
    int                rd_cyc = 0;
    logic              fr_src = 1'b0;
    logic [DATA_W-1:0] fr_left = '0;
    logic [DATA_W-1:0] fr_right = '0;
    logic [DATA_W-1:0] last_left = '0;
    logic [DATA_W-1:0] last_right = '0;
    logic [ADDR_W-1:0] exp_addr = '0;
    int                stall_model = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic m, input logic f,
                                input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                                input int st, input logic [DATA_W-1:0] el,
                                input logic [DATA_W-1:0] er, input logic [ADDR_W-1:0] ea,
                                input logic [15:0] es);
        vec_t v;
        v.src = s; v.mute = m; v.flip = f; v.left = l; v.right = r; v.stall = st;
        v.exp_left = el; v.exp_right = er; v.exp_addr = ea; v.exp_stall = es;
        return v;
    endfunction

    // A write is due in the first cycle at least ROM_LAT+1 after the read where the DAC is ready;
    // every cycle of that window spent waiting is a stall.
    task automatic monitor();
        int   e;
        logic exp_write;
        logic was_pending;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_seen != rst_req) begin
                rst_seen    = rst_req;
                pending     = 1'b0;
                exp_addr    = '0;
                stall_model = 0;
                last_left   = '0;
                last_right  = '0;
            end
            if (!reset_n) continue;
            was_pending = pending;
            e = cyc - rd_cyc;
            exp_write = pending && (e >= ROM_LAT + 1) && codec_if.write_ready;
            check("write_strobe", 64'(codec_if.write), 64'(exp_write));
            check("frame_done", 64'(frame_done), 64'(exp_write));
            check("rom_addr", 64'(rom_addr), 64'(exp_addr));
            if (pending && e >= ROM_LAT + 1) begin
                check("writedata_left", 64'(codec_if.writedata_left), 64'(fr_left));
                check("writedata_right", 64'(codec_if.writedata_right), 64'(fr_right));
            end else begin
                check("hold_left", 64'(codec_if.writedata_left), 64'(last_left));
                check("hold_right", 64'(codec_if.writedata_right), 64'(last_right));
            end
            if (!(codec_if.read_ready && !was_pending))
                check("read_spurious", 64'(codec_if.read), 64'd0);
            if (exp_write) begin
                stall_model += e - (ROM_LAT + 1);
                check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
                last_left  = fr_left;
                last_right = fr_right;
                if (fr_src) exp_addr = (int'(exp_addr) == TONE_LEN - 1) ? '0 : exp_addr + 1'b1;
                pending = 1'b0;
            end
            if (codec_if.read && codec_if.read_ready && !was_pending) begin
                pending  = 1'b1;
                rd_cyc   = cyc;
                fr_src   = src_sel;
                fr_left  = mute ? '0 : (src_sel ? rom_model(exp_addr) : codec_if.readdata_left);
                fr_right = mute ? '0 : (src_sel ? rom_model(exp_addr) : codec_if.readdata_right);
            end
        end
    endtask

    task automatic wait_read(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (codec_if.read) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("read_seen", 64'(seen), 64'd1);
    endtask

    task automatic applyStimulus(input vec_t v, output res_t r);
        logic seen;
        r.got = 1'b0; r.lat = 0; r.left = '0; r.right = '0; r.addr = '0; r.stall = '0;
        @(posedge clk);
        #1;
        src_sel = v.src;
        mute    = v.mute;
        codec_if.readdata_left  = v.left;
        codec_if.readdata_right = v.right;
        codec_if.read_ready  = 1'b1;
        codec_if.write_ready = 1'b1;
        wait_read(seen);
        if (!seen) return;
        for (int k = 1; k <= 40 && !r.got; k++) begin
            @(posedge clk);
            #1;
            codec_if.read_ready = 1'b0;
            codec_if.readdata_left  = 24'($urandom);
            codec_if.readdata_right = 24'($urandom);
            if (v.flip && k == 1) src_sel = ~v.src;
            codec_if.write_ready = (k >= ROM_LAT + 1 + v.stall);
            @(negedge clk);
            if (codec_if.write) begin
                r.got   = 1'b1;
                r.lat   = k;
                r.left  = codec_if.writedata_left;
                r.right = codec_if.writedata_right;
                r.addr  = rom_addr;
                r.stall = stall_cnt;
            end
        end
    endtask

    task automatic checkOutput(input vec_t v, input res_t r);
        check("write_seen", 64'(r.got), 64'd1);
        check("latency", 64'(r.lat), 64'(ROM_LAT + 1 + v.stall));
        check("frame_left", 64'(r.left), 64'(v.exp_left));
        check("frame_right", 64'(r.right), 64'(v.exp_right));
        check("frame_addr", 64'(r.addr), 64'(v.exp_addr));
        check("frame_stall", 64'(r.stall), 64'(v.exp_stall));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"}, 64'(codec_if.read), 64'd0);
        check({tag, "_write"}, 64'(codec_if.write), 64'd0);
        check({tag, "_done"}, 64'(frame_done), 64'd0);
        check({tag, "_wd_left"}, 64'(codec_if.writedata_left), 64'd0);
        check({tag, "_wd_right"}, 64'(codec_if.writedata_right), 64'd0);
        check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        logic seen;
        vecs[0] = mk(0, 0, 0, 24'h123456, 24'hABCDEF, 0, 24'h123456, 24'hABCDEF, 0, 0);
        for (int i = 1; i <= 6; i++)
            vecs[i] = mk(1, 0, 0, 24'h0F0F00 + 24'(i), 24'hF0F000 + 24'(i), 0,
                         rom_model(16'((i - 1) % TONE_LEN)), rom_model(16'((i - 1) % TONE_LEN)),
                         16'((i - 1) % TONE_LEN), 0);
        vecs[7]  = mk(0, 0, 0, 24'h111111, 24'h222222, 5, 24'h111111, 24'h222222, 2, 5);
        vecs[8]  = mk(1, 1, 0, 24'h333333, 24'h333333, 0, 24'h0, 24'h0, 2, 5);
        vecs[9]  = mk(1, 1, 0, 24'h333333, 24'h333333, 0, 24'h0, 24'h0, 3, 5);
        vecs[10] = mk(1, 0, 0, 24'h777777, 24'h888888, 0, rom_model(0), rom_model(0), 0, 5);
        vecs[11] = mk(1, 0, 1, 24'h999999, 24'hAAAAAA, 0, rom_model(1), rom_model(1), 1, 5);
        vecs[12] = mk(0, 0, 0, 24'h444444, 24'h555555, 0, 24'h444444, 24'h555555, 2, 5);
        post_reset_vec = mk(1, 0, 0, 24'h666666, 24'h666666, 0, rom_model(0), rom_model(0), 0, 0);

        codec_if.read_ready = 1'b0;
        codec_if.write_ready = 1'b0;
        codec_if.readdata_left = '0;
        codec_if.readdata_right = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset_n = 1'b1;
        fork
            monitor();
        join_none

        $display("[TB] directed frame table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], res);
            checkOutput(vecs[i], res);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            codec_if.read_ready  = ($urandom_range(0, 3) != 0);
            codec_if.write_ready = ($urandom_range(0, 3) != 0);
            src_sel = 1'($urandom);
            mute    = ($urandom_range(0, 3) == 0);
            codec_if.readdata_left  = 24'($urandom);
            codec_if.readdata_right = 24'($urandom);
        end
        @(posedge clk);
        #1;
        codec_if.read_ready  = 1'b0;
        codec_if.write_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("[TB] asynchronous reset during FETCH");
        #1;
        src_sel = 1'b1;
        mute    = 1'b0;
        codec_if.read_ready  = 1'b1;
        codec_if.write_ready = 1'b1;
        wait_read(seen);
        @(posedge clk);
        #1;
        codec_if.read_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        rst_req++;
        #1;
        check_all_zero("midreset");
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_no_write", 64'(codec_if.write), 64'd0);
        end
        applyStimulus(post_reset_vec, res);
        checkOutput(post_reset_vec, res);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
